// File: rtl/axi4_pkg.sv
// Shared AXI4 read-side types: burst kinds, response codes and the slave FSM states.
package axi4_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_RESP  = 2'b10
  } state_e;

  localparam logic [2:0] SIZE_WORD = 3'b010;

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/inst_mem_bram.sv
// DEPTH x 32 simple dual-port RAM, one write and one registered read port, read-first.
module inst_mem_bram #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Contents are deliberately not reset so a preloaded program survives rst.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi4_slave_inst_mem.sv
// AXI4 read-only slave over an instruction RAM: one burst at a time, one beat per two cycles.
module axi4_slave_inst_mem
  import axi4_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4,
  parameter int DEPTH  = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ID_W-1:0]          ARID,
  input  logic [ADDR_W-1:0]        ARADDR,
  input  logic [7:0]               ARLEN,
  input  logic [2:0]               ARSIZE,
  input  logic [1:0]               ARBURST,
  input  logic [3:0]               ARREGION,
  input  logic                     ARLOCK,
  input  logic [3:0]               ARCACHE,
  input  logic [2:0]               ARPROT,
  input  logic [3:0]               ARQOS,
  input  logic                     ARVALID,
  output logic                     ARREADY,
  output logic [ID_W-1:0]          RID,
  output logic [31:0]              RDATA,
  output logic [1:0]               RRESP,
  output logic                     RLAST,
  output logic                     RVALID,
  input  logic                     RREADY,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data,
  output state_e                   dbg_state
);

  localparam int AW = $clog2(DEPTH);

  // Handshake: AR transfers on an edge where ARVALID && ARREADY; R transfers on an
  // edge where RVALID && RREADY, and RID/RDATA/RRESP/RLAST hold until that edge.

  state_e            state;
  logic              arready_q, rvalid_q, rlast_q, zero_q;
  logic              size_err_q, burst_err_q;
  resp_e             rresp_q;
  burst_e            burst_q;
  logic [ID_W-1:0]   rid_q;
  logic [ADDR_W-1:0] addr_q, next_addr, incr_addr, wrap_mask;
  logic [7:0]        cnt_q, len_q;
  logic [31:0]       mem_q;
  logic              oob, wrap_bad;

  wire unused_ar = ^{ARREGION, ARLOCK, ARCACHE, ARPROT, ARQOS};

  assign oob      = |addr_q[ADDR_W-1:AW+2];
  assign wrap_bad = (ARBURST == BURST_RSVD) || (ARBURST == BURST_WRAP && !wrap_len_ok(ARLEN));

  // WRAP mask is (len+1)*4-1, valid because len is restricted to 2^n-1.
  always_comb begin
    incr_addr = addr_q + ADDR_W'(4);
    wrap_mask = ADDR_W'({len_q, 2'b11});
    case (burst_q)
      BURST_FIXED: next_addr = addr_q;
      BURST_WRAP:  next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = incr_addr;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      zero_q      <= 1'b0;
      rresp_q     <= RESP_OKAY;
      rid_q       <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      burst_q     <= BURST_FIXED;
      size_err_q  <= 1'b0;
      burst_err_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (arready_q && ARVALID) begin
            arready_q   <= 1'b0;
            rid_q       <= ARID;
            addr_q      <= ARADDR;
            cnt_q       <= ARLEN;
            len_q       <= ARLEN;
            burst_q     <= wrap_bad ? BURST_INCR : burst_e'(ARBURST);
            burst_err_q <= wrap_bad;
            size_err_q  <= (ARSIZE != SIZE_WORD);
            state       <= S_FETCH;
          end else begin
            arready_q <= 1'b1;
          end
        end
        S_FETCH: begin
          rvalid_q <= 1'b1;
          rlast_q  <= (cnt_q == 8'd0);
          zero_q   <= size_err_q || oob;
          if (size_err_q || burst_err_q) rresp_q <= RESP_SLVERR;
          else if (oob)                  rresp_q <= RESP_DECERR;
          else                           rresp_q <= RESP_OKAY;
          state    <= S_RESP;
        end
        S_RESP: begin
          if (RREADY) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            if (rlast_q) begin
              arready_q <= 1'b1;
              state     <= S_IDLE;
            end else begin
              addr_q <= next_addr;
              cnt_q  <= cnt_q - 8'd1;
              state  <= S_FETCH;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  inst_mem_bram #(.DEPTH(DEPTH), .AW(AW)) u_bram (
    .clk   (clk),
    .rst   (rst),
    .we    (load_en),
    .waddr (load_addr),
    .wdata (load_data),
    .re    (state == S_FETCH),
    .raddr (addr_q[AW+1:2]),
    .rdata (mem_q)
  );

  assign ARREADY   = arready_q;
  assign RVALID    = rvalid_q;
  assign RLAST     = rlast_q;
  assign RRESP     = rresp_q;
  assign RID       = rid_q;
  assign RDATA     = zero_q ? 32'd0 : mem_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_axi4_slave_inst_mem.sv
// Directed bench for axi4_slave_inst_mem: bursts, stalls, error responses and mid-burst reset.
module tb_axi4_slave_inst_mem;
  import axi4_pkg::*;

  localparam int ADDR_W = 32;
  localparam int ID_W   = 4;
  localparam int DEPTH  = 64;
  localparam int AW     = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ID_W-1:0]   ARID = '0;
  logic [ADDR_W-1:0] ARADDR = '0;
  logic [7:0]        ARLEN = '0;
  logic [2:0]        ARSIZE = 3'b010;
  logic [1:0]        ARBURST = 2'b01;
  logic [3:0]        ARREGION = '0;
  logic              ARLOCK = 1'b0;
  logic [3:0]        ARCACHE = '0;
  logic [2:0]        ARPROT = '0;
  logic [3:0]        ARQOS = '0;
  logic              ARVALID = 1'b0;
  logic              ARREADY;
  logic [ID_W-1:0]   RID;
  logic [31:0]       RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY = 1'b0;
  logic              load_en = 1'b0;
  logic [AW-1:0]     load_addr = '0;
  logic [31:0]       load_data = '0;
  state_e            dbg_state;

  int checks = 0;
  int errors = 0;

  axi4_slave_inst_mem #(.ADDR_W(ADDR_W), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARREGION(ARREGION), .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARQOS(ARQOS),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    step();
    load_en = 1'b0;
  endtask

  // Returns at posedge+1 just after the AR handshake edge.
  task automatic do_ar(input logic [ID_W-1:0] id, input logic [31:0] addr,
                       input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    while (!ARREADY && n < 20) begin step(); n++; end
    check("arready_wait", ARREADY, 1'b1);
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    step();
    ARVALID = 1'b0;
  endtask

  task automatic recv_beat(input string tag, input logic [31:0] exp_data, input logic [1:0] exp_resp,
                           input logic exp_last, input logic [ID_W-1:0] exp_id, input int stall);
    int n = 0;
    while (!RVALID && n < 20) begin step(); n++; end
    check({tag, "_rvalid"}, RVALID, 1'b1);
    check({tag, "_rdata"}, RDATA, exp_data);
    check({tag, "_rresp"}, RRESP, exp_resp);
    check({tag, "_rlast"}, RLAST, exp_last);
    check({tag, "_rid"}, RID, exp_id);
    for (int i = 0; i < stall; i++) begin
      step();
      check({tag, "_stall_rvalid"}, RVALID, 1'b1);
      check({tag, "_stall_rdata"}, RDATA, exp_data);
      check({tag, "_stall_rlast"}, RLAST, exp_last);
    end
    RREADY = 1'b1;
    step();
    RREADY = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) step();
    check("rst_arready", ARREADY, 1'b0);
    check("rst_rvalid", RVALID, 1'b0);
    check("rst_rlast", RLAST, 1'b0);
    check("rst_rdata", RDATA, 32'h0);
    check("rst_rresp", RRESP, 2'b00);
    check("rst_rid", RID, 4'h0);
    rst = 1'b0;
    step();
    check("post_rst_arready", ARREADY, 1'b1);

    load_word(6'd0, 32'h11);
    load_word(6'd1, 32'h22);
    load_word(6'd2, 32'h33);
    load_word(6'd3, 32'h44);
    load_word(6'd63, 32'hABCD);

    // INCR 4 beats, with two-cycle AR-to-RVALID latency
    do_ar(4'h5, 32'h0, 8'd3, 3'b010, 2'b01);
    check("lat_edge1_rvalid", RVALID, 1'b0);
    step();
    check("lat_edge2_rvalid", RVALID, 1'b1);
    recv_beat("incr_b0", 32'h11, 2'b00, 1'b0, 4'h5, 0);
    check("incr_gap_rvalid", RVALID, 1'b0);
    recv_beat("incr_b1", 32'h22, 2'b00, 1'b0, 4'h5, 0);
    recv_beat("incr_b2", 32'h33, 2'b00, 1'b0, 4'h5, 0);
    recv_beat("incr_b3", 32'h44, 2'b00, 1'b1, 4'h5, 0);

    // WRAP 4 beats from word 2
    do_ar(4'h6, 32'h8, 8'd3, 3'b010, 2'b10);
    recv_beat("wrap_b0", 32'h33, 2'b00, 1'b0, 4'h6, 0);
    recv_beat("wrap_b1", 32'h44, 2'b00, 1'b0, 4'h6, 0);
    recv_beat("wrap_b2", 32'h11, 2'b00, 1'b0, 4'h6, 0);
    recv_beat("wrap_b3", 32'h22, 2'b00, 1'b1, 4'h6, 0);

    // RREADY held low for 5 cycles on beat 1
    do_ar(4'h1, 32'h0, 8'd1, 3'b010, 2'b01);
    recv_beat("stall_b0", 32'h11, 2'b00, 1'b0, 4'h1, 0);
    recv_beat("stall_b1", 32'h22, 2'b00, 1'b1, 4'h1, 5);
    check("stall_done_rvalid", RVALID, 1'b0);

    // Last word then beyond the memory: DECERR with zero data
    do_ar(4'h2, (DEPTH - 1) * 4, 8'd1, 3'b010, 2'b01);
    recv_beat("oob_b0", 32'hABCD, 2'b00, 1'b0, 4'h2, 0);
    recv_beat("oob_b1", 32'h0, 2'b11, 1'b1, 4'h2, 0);

    // Unsupported size: zero data, SLVERR on every beat
    do_ar(4'h3, 32'h0, 8'd1, 3'b001, 2'b01);
    recv_beat("size_b0", 32'h0, 2'b10, 1'b0, 4'h3, 0);
    recv_beat("size_b1", 32'h0, 2'b10, 1'b1, 4'h3, 0);

    // FIXED burst repeats the same word
    do_ar(4'h4, 32'h4, 8'd2, 3'b010, 2'b00);
    recv_beat("fixed_b0", 32'h22, 2'b00, 1'b0, 4'h4, 0);
    recv_beat("fixed_b1", 32'h22, 2'b00, 1'b0, 4'h4, 0);
    recv_beat("fixed_b2", 32'h22, 2'b00, 1'b1, 4'h4, 0);

    // Illegal WRAP length runs as INCR with SLVERR
    do_ar(4'h7, 32'h0, 8'd2, 3'b010, 2'b10);
    recv_beat("badwrap_b0", 32'h11, 2'b10, 1'b0, 4'h7, 0);
    recv_beat("badwrap_b1", 32'h22, 2'b10, 1'b0, 4'h7, 0);
    recv_beat("badwrap_b2", 32'h33, 2'b10, 1'b1, 4'h7, 0);

    // Backdoor write to the word being fetched returns the old data
    do_ar(4'h8, 32'hC, 8'd0, 3'b010, 2'b01);
    load_en = 1'b1; load_addr = 6'd3; load_data = 32'h99;
    step();
    load_en = 1'b0;
    recv_beat("rf_old", 32'h44, 2'b00, 1'b1, 4'h8, 0);
    do_ar(4'h8, 32'hC, 8'd0, 3'b010, 2'b01);
    recv_beat("rf_new", 32'h99, 2'b00, 1'b1, 4'h8, 0);

    // Reset during beat 2 of an 8-beat burst
    do_ar(4'hA, 32'h0, 8'd7, 3'b010, 2'b01);
    recv_beat("abort_b0", 32'h11, 2'b00, 1'b0, 4'hA, 0);
    recv_beat("abort_b1", 32'h22, 2'b00, 1'b0, 4'hA, 0);
    begin
      int n = 0;
      while (!RVALID && n < 20) begin step(); n++; end
    end
    check("abort_b2_rvalid", RVALID, 1'b1);
    check("abort_b2_rdata", RDATA, 32'h33);
    #2;
    rst = 1'b1;
    #1;
    check("abort_rvalid_async", RVALID, 1'b0);
    check("abort_arready", ARREADY, 1'b0);
    check("abort_rdata", RDATA, 32'h0);
    step();
    step();
    check("abort_held_rvalid", RVALID, 1'b0);
    rst = 1'b0;
    step();
    check("abort_release_arready", ARREADY, 1'b1);
    check("abort_release_rvalid", RVALID, 1'b0);
    do_ar(4'h9, 32'h4, 8'd0, 3'b010, 2'b01);
    recv_beat("after_rst", 32'h22, 2'b00, 1'b1, 4'h9, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_slave_inst_mem.md
AXI4_SLAVE_INST_MEM -- requirements
Module: axi4_slave_inst_mem

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high, on ports clk and rst.
REQ-002 SHALL take parameter ADDR_W, default 32: AXI address width.
REQ-003 SHALL take parameter ID_W, default 4: ARID/RID width.
REQ-004 SHALL take parameter DEPTH, default 4096: memory size in 32-bit words, power of two.
REQ-005 SHALL have clk  input  1  clock; all logic on the rising edge.
REQ-006 SHALL have rst  input  1  asynchronous active-high reset.
REQ-007 SHALL have ARID  input  ID_W  read transaction ID.
REQ-008 SHALL have ARADDR  input  ADDR_W  byte address of the first beat.
REQ-009 SHALL have ARLEN  input  8  beats minus one.
REQ-010 SHALL have ARSIZE  input  3  beat size; only 3'b010 is supported.
REQ-011 SHALL have ARBURST  input  2  burst type: FIXED 00, INCR 01, WRAP 10.
REQ-012 SHALL have ARVALID  input  1  address valid.
REQ-013 SHALL have ARREADY  output  1  address accepted.
REQ-014 SHALL have RID  output  ID_W  echoed ARID.
REQ-015 SHALL have RDATA  output  32  read data.
REQ-016 SHALL have RRESP  output  2  OKAY 00, SLVERR 10, DECERR 11.
REQ-017 SHALL have RLAST  output  1  final beat of the burst.
REQ-018 SHALL have RVALID  output  1  data valid.
REQ-019 SHALL have RREADY  input  1  master accepts data.
REQ-020 SHALL have ARREGION, ARLOCK, ARCACHE, ARPROT and ARQOS as inputs; they are ignored.
REQ-021 SHALL have load_en  input  1  backdoor word write (program preload).
REQ-022 SHALL have load_addr  input  $clog2(DEPTH)  backdoor word index.
REQ-023 SHALL have load_data  input  32  backdoor write data.

Function
REQ-024 SHALL use a three-state FSM: S_IDLE, S_FETCH, S_RESP; one outstanding burst at a time.
REQ-025 SHALL drive ARREADY = (state == S_IDLE); S_IDLE + ARVALID latches ID/ADDR/LEN/SIZE/BURST, sets beat counter = ARLEN, and goes to S_FETCH.
REQ-026 SHALL issue the synchronous memory read for the current beat address in S_FETCH and go to S_RESP next cycle.
REQ-027 SHALL in S_RESP drive RVALID=1 and hold RDATA/RRESP/RLAST/RID stable until RVALID&&RREADY.
REQ-028 SHALL on a non-last beat handshake advance the address and go to S_FETCH; on the last beat, return to S_IDLE.
REQ-029 SHALL have an AR-handshake-to-first-RVALID latency of 2 cycles; beat throughput is 1 per 2 cycles with RREADY held high.
REQ-030 SHALL advance the address as follows: FIXED holds it; INCR adds 4; WRAP adds 4 modulo (ARLEN+1)*4, aligned to that boundary.
REQ-031 SHALL treat WRAP with ARLEN not in {1,3,7,15}, or ARBURST=11, as INCR, with RRESP=SLVERR on all beats.
REQ-032 SHALL for ARSIZE != 3'b010 return ARLEN+1 beats with RDATA=0 and RRESP=SLVERR.
REQ-033 SHALL for a beat whose word index is >= DEPTH return RDATA=0 and RRESP=DECERR; other beats in the same burst are unaffected.
REQ-034 SHALL assert RLAST exactly when the beat counter is 0; bursts of 256 beats (ARLEN=255) are supported.
REQ-035 SHALL ignore bits [1:0] of ARADDR for the data lookup.
REQ-036 SHALL apply load_en writes every cycle regardless of FSM state.
REQ-037 SHALL be read-first when load_en hits the word read in the same S_FETCH cycle: the beat returns the old data.

Reset
REQ-038 SHALL while rst is high force: state=S_IDLE, ARREADY=0, RVALID=0, RLAST=0, RDATA=0, RRESP=0, RID=0, and the counter and address registers to 0.
REQ-039 SHALL abort a burst when rst asserts mid-burst: RVALID falls asynchronously and no further beats are sent.
REQ-040 SHALL raise ARREADY on the first clk edge after rst deasserts; memory contents are not reset.

Structure
REQ-041 SHALL place the burst type, response code and FSM state enums in the shared package axi4_pkg.
REQ-042 SHALL instantiate one sub-module, inst_mem_bram: 1R1W synchronous RAM, read-first, DEPTH x 32.

Verification
REQ-043 SHALL cover: preload words 0..3 = 0x11,0x22,0x33,0x44; INCR ARADDR=0 ARLEN=3 -> four OKAY beats in order, RLAST on the 4th, first RVALID 2 cycles after AR.
REQ-044 SHALL cover: WRAP ARADDR=0x8 ARLEN=3 -> data from words 2,3,0,1.
REQ-045 SHALL cover: RREADY low for 5 cycles on beat 1 -> RDATA/RLAST stable throughout, no beat lost.
REQ-046 SHALL cover: ARADDR=(DEPTH-1)*4, INCR ARLEN=1 -> beat0 OKAY, beat1 DECERR with RDATA 0; ARSIZE=3'b001 -> all SLVERR.
REQ-047 SHALL cover: rst pulse during beat 2 of an 8-beat burst -> RVALID drops immediately; a new AR is accepted one cycle after release.
